dmi_host_bridge: RTL and testbench
==================================

# dmi_host_bridge

Converts simple host-bus accesses into single debug-module-interface (DMI) transactions. An SoC-side debug host (boot ROM agent, UART monitor, test controller) uses it to reach the DM registers without a JTAG DTM. It sits directly upstream of the debug module top and drives its DMI request, response and DMI-reset inputs. It is blocking (one transaction in flight), bounds every transaction with a timeout, and recovers a hung DMI link by pulsing DMI reset.

## Interface
- TimeoutCycles, 1024: cycles allowed from DMI request issue to response. Value 0 disables the timeout.
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- host_req_i  in  1  host access request; held until granted.
- host_we_i  in  1  1 = write, 0 = read.
- host_addr_i  in  9  byte address; bits [8:2] form the DMI address, bits [1:0] are ignored.
- host_wdata_i  in  32  write data.
- host_gnt_o  out  1  request accepted this cycle.
- host_rvalid_o  out  1  one-cycle completion pulse, for reads and writes.
- host_rdata_o  out  32  read data, valid with host_rvalid_o; 0 for writes and on error.
- host_err_o  out  1  completion error, valid with host_rvalid_o.
- dmi_rst_no  out  1  DMI reset to the DM, active-low.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DMI request ready.
- dmi_req_o  out  dm::dmi_req_t  carries addr, op (DTM_READ/DTM_WRITE) and data.
- dmi_resp_valid_i  in  1  DMI response valid.
- dmi_resp_ready_o  out  1  DMI response ready.
- dmi_resp_i  in  dm::dmi_resp_t  carries data and resp.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - host_gnt_o = host_req_i, combinationally.
  - On grant, latch addr[8:2], op and wdata into dmi_req_o. Go to REQ.
- REQ:
  - dmi_req_valid_o = 1. dmi_req_o is stable while valid.
  - On dmi_req_valid_o & dmi_req_ready_i, go to WAIT.
- WAIT:
  - dmi_resp_ready_o = 1.
  - On dmi_resp_valid_i, capture the response:
    - read with resp == DTM_SUCCESS: rdata = response data, err = 0.
    - write with resp == DTM_SUCCESS: rdata = 0, err = 0.
    - any other resp: rdata = 0, err = 1.
  - Go to DONE.
- DONE: host_rvalid_o = 1 for exactly this cycle, with host_rdata_o and host_err_o. Go to IDLE.
- host_gnt_o is 0 in every state except IDLE. There is never more than one outstanding access.
- Timeout counter:
  - Clears on entry to REQ. Increments every cycle in REQ and WAIT.
  - Expiry: counter == TimeoutCycles-1 in REQ or WAIT and no handshake completes that cycle.
  - On expiry: drop dmi_req_valid_o and dmi_resp_ready_o, drive dmi_rst_no low for exactly the next cycle, report err = 1 with rdata = 0 in DONE.
  - In the DONE cycle after a timeout, dmi_rst_no = 0. It returns to 1 in the following cycle.
- Simultaneous events:
  - A handshake in the expiry cycle wins: the transaction proceeds normally and there is no reset pulse.
  - host_req_i during DONE is not granted. It waits for IDLE.
- Late response after a timeout: the DM discards it via DMI reset. Any dmi_resp_valid_i seen in IDLE is ignored (ready = 0).

## Timing
- Reset values:
  - state IDLE.
  - host_gnt_o 0 (host_req_i is ignored during reset).
  - host_rvalid_o 0, host_rdata_o 0, host_err_o 0.
  - dmi_req_valid_o 0, dmi_req_o all-zero (op = DTM_NOP).
  - dmi_resp_ready_o 0.
  - dmi_rst_no 0; it rises to 1 on the first clock edge after rst_ni deasserts.
- All outputs except host_gnt_o are registered.
- Minimum latency, with ready and response each arriving on their first eligible cycle:
  - grant at cycle 0.
  - request handshake at cycle 1.
  - response handshake at cycle 2.
  - host_rvalid_o at cycle 3.
  - next grant possible at cycle 4.
- Reset asserted mid-transaction aborts immediately to the reset values, with no completion pulse.

## Structure
- Reuse dm::dmi_req_t, dm::dmi_resp_t, dm::dtm_op_e and DTM_SUCCESS from the dm package. Add no new package types.
- The FSM state enum is local to the module.
- Single module, no sub-module. Counter width is $clog2(TimeoutCycles+1), with a minimum of 1.

## Test plan
- Read: host reads address 0x44 (DMI 0x11, dmstatus); DM returns data 0x00400382, resp 0 → dmi_req_o.addr = 0x11, op = DTM_READ; host_rdata_o = 0x00400382, err = 0; rvalid 3 cycles after grant.
- Write: host writes 0x80000001 to 0x40 (dmcontrol) with dmi_req_ready_i held low for 5 cycles → dmi_req_o is stable throughout; one completion pulse with rdata = 0, err = 0.
- Error response: resp = 2 on a read → err = 1, rdata = 0.
- Timeout: TimeoutCycles = 8, response never arrives → at the 8th REQ/WAIT cycle valid/ready drop; the next cycle shows dmi_rst_no = 0 and rvalid with err = 1; the following cycle dmi_rst_no = 1.
- Race: response handshake exactly in the expiry cycle → normal completion with err = 0 and no reset pulse.
- Back-to-back: host_req_i held high for two accesses → second grant comes 4 cycles after the first; a request in DONE is not granted; rst_ni pulsed in WAIT → all outputs return to reset values with no rvalid.

Source files
------------

// File: rtl/dm_pkg.sv
// Debug-module interface types shared with the debug module top.
// The bridge reuses these request/response encodings unchanged.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_host_bridge.sv
// Host-bus to DMI bridge: one blocking DMI access at a time, bounded by a
// timeout that recovers a hung link by pulsing DMI reset for one cycle.
module dmi_host_bridge
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [8:0]    host_addr_i,
  input  logic [31:0]   host_wdata_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [31:0]   host_rdata_o,
  output logic          host_err_o,
  output logic          dmi_rst_no,
  output logic          dmi_req_valid_o,
  input  logic          dmi_req_ready_i,
  output dm::dmi_req_t  dmi_req_o,
  input  logic          dmi_resp_valid_i,
  output logic          dmi_resp_ready_o,
  input  dm::dmi_resp_t dmi_resp_i
);

  localparam int unsigned CntW = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 1;
  localparam logic [CntW-1:0] CntMax =
    (TimeoutCycles > 32'd0) ? CntW'(TimeoutCycles - 32'd1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dmi_req_t        req_q, req_d;
  logic            req_valid_q, req_valid_d;
  logic            resp_ready_q, resp_ready_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            dmi_rst_n_q, dmi_rst_n_d;

  logic gnt_s, req_hs_s, resp_hs_s, expire_s, busy_s;
  logic unused_addr_s;

  assign unused_addr_s = ^host_addr_i[1:0];

  // Grant is the only combinational output; held off while reset is asserted.
  assign gnt_s     = (state_q == IDLE) && host_req_i && rst_ni;
  assign req_hs_s  = req_valid_q && dmi_req_ready_i;
  assign resp_hs_s = resp_ready_q && dmi_resp_valid_i;
  assign busy_s    = (state_q == REQ) || (state_q == WAIT);
  // A handshake in the last allowed cycle beats the timeout.
  assign expire_s  = (TimeoutCycles != 32'd0) && busy_s && (cnt_q == CntMax)
                     && !req_hs_s && !resp_hs_s;

  assign host_gnt_o       = gnt_s;
  assign host_rvalid_o    = rvalid_q;
  assign host_rdata_o     = rdata_q;
  assign host_err_o       = err_q;
  assign dmi_rst_no       = dmi_rst_n_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_o        = req_q;
  assign dmi_resp_ready_o = resp_ready_q;

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      dmi_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      dmi_rst_n_q  <= dmi_rst_n_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_s) state_d = REQ;
        else       state_d = IDLE;
      end
      REQ: begin
        if (req_hs_s)      state_d = WAIT;
        else if (expire_s) state_d = DONE;
        else               state_d = REQ;
      end
      WAIT: begin
        if (resp_hs_s)     state_d = DONE;
        else if (expire_s) state_d = DONE;
        else               state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; counter saturates so a request accepted
  // in the last allowed cycle still expires if no response follows at once.
  always_comb begin
    req_d   = req_q;
    cnt_d   = '0;
    rdata_d = 32'd0;
    err_d   = 1'b0;

    if (gnt_s) begin
      req_d.addr = host_addr_i[8:2];
      req_d.op   = host_we_i ? DTM_WRITE : DTM_READ;
      req_d.data = host_wdata_i;
    end else begin
      req_d = req_q;
    end

    if (busy_s && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (busy_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = '0;
    end

    if (resp_hs_s) begin
      err_d = (dmi_resp_i.resp != DTM_SUCCESS);
      if ((req_q.op == DTM_READ) && (dmi_resp_i.resp == DTM_SUCCESS)) begin
        rdata_d = dmi_resp_i.data;
      end else begin
        rdata_d = 32'd0;
      end
    end else if (expire_s) begin
      err_d   = 1'b1;
      rdata_d = 32'd0;
    end else begin
      err_d   = 1'b0;
      rdata_d = 32'd0;
    end

    req_valid_d  = (state_d == REQ);
    resp_ready_d = (state_d == WAIT);
    rvalid_d     = (state_d == DONE);
    dmi_rst_n_d  = !expire_s;
  end

endmodule

// File: tb/tb_dmi_host_bridge.sv
// Self-checking bench for dmi_host_bridge: directed scenarios plus randomized
// transactions checked against a cycle-budget model of each access.
module tb_dmi_host_bridge;
  import dm::*;

  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          host_req_i, host_we_i;
  logic [8:0]    host_addr_i;
  logic [31:0]   host_wdata_i;
  logic          host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0]   host_rdata_o;
  logic          dmi_rst_no, dmi_req_valid_o, dmi_req_ready_i;
  dmi_req_t      dmi_req_o;
  logic          dmi_resp_valid_i, dmi_resp_ready_o;
  dmi_resp_t     dmi_resp_i;

  int n_assert = 0;
  int n_fail   = 0;

  dmi_host_bridge #(.TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o), .dmi_rst_no(dmi_rst_no),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_o(dmi_req_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_i(dmi_resp_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One host access. The DM raises ready dr cycles late and answers ds cycles
  // after the request handshake. Cycle 0 is the grant; the model places each
  // handshake inside a budget of TO cycles counted from cycle 1.
  task automatic run_txn(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                         input int dr, input int ds, input logic [1:0] rc,
                         input logic [31:0] rd);
    int k1, k2, end_cyc, done_cyc, last_cyc, lim;
    bit to, e_err;
    logic [31:0] e_rdata;
    dmi_req_t e_req;
    k1 = dr + 1;
    k2 = k1 + 1 + ds;
    lim = (k1 + 1 > TO) ? k1 + 1 : TO;
    if (k1 > TO) begin
      to = 1'b1; end_cyc = TO;
    end else if (k2 > lim) begin
      to = 1'b1; end_cyc = lim;
    end else begin
      to = 1'b0; end_cyc = k2;
    end
    done_cyc = end_cyc + 1;
    e_err    = to || (rc != DTM_SUCCESS);
    e_rdata  = (!e_err && !we) ? rd : 32'd0;
    e_req.addr = addr[8:2];
    e_req.op   = we ? DTM_WRITE : DTM_READ;
    e_req.data = wdata;
    last_cyc = (k2 > done_cyc + 1) ? k2 : done_cyc + 1;

    @(negedge clk_i);
    host_req_i = 1'b1; host_we_i = we; host_addr_i = addr; host_wdata_i = wdata;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_i = '{data: rd, resp: rc};
    #1;
    chk1("gnt", host_gnt_o, 1'b1);
    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clk_i);
      host_req_i   = 1'b0;
      host_we_i    = 1'($urandom);
      host_addr_i  = 9'($urandom);
      host_wdata_i = $urandom;
      dmi_req_ready_i  = (c >= k1);
      dmi_resp_valid_i = (c == k2);
      #1;
      chk1("req_valid", dmi_req_valid_o, (c <= k1) && (c <= end_cyc));
      chk1("resp_ready", dmi_resp_ready_o, (c > k1) && (c <= end_cyc));
      chk1("rvalid", host_rvalid_o, c == done_cyc);
      chk1("dmi_rst_n", dmi_rst_no, !(to && (c == done_cyc)));
      if (c <= end_cyc) chkw("req_o", 64'(dmi_req_o), 64'(e_req));
      if (c == done_cyc) begin
        chkw("rdata", 64'(host_rdata_o), 64'(e_rdata));
        chk1("err", host_err_o, e_err);
      end
    end
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
  endtask

  initial begin
    logic        we_v;
    logic [8:0]  addr_v;
    logic [31:0] wd_v, rd_v;
    logic [1:0]  rc_v;
    logic [1:0]  codes [4];
    codes[0] = 2'd0; codes[1] = 2'd0; codes[2] = 2'd2; codes[3] = 2'd3;

    // Reset values, with a host request pending during reset
    rst_ni = 1'b0; host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 9'h44;
    host_wdata_i = 32'd0; dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1;
    dmi_resp_i = '{data: 32'hDEAD_BEEF, resp: 2'd0};
    repeat (2) @(negedge clk_i);
    #1;
    chk1("rst_gnt", host_gnt_o, 1'b0);
    chk1("rst_rvalid", host_rvalid_o, 1'b0);
    chkw("rst_rdata", 64'(host_rdata_o), 64'd0);
    chk1("rst_err", host_err_o, 1'b0);
    chk1("rst_req_valid", dmi_req_valid_o, 1'b0);
    chkw("rst_req_o", 64'(dmi_req_o), 64'd0);
    chk1("rst_resp_ready", dmi_resp_ready_o, 1'b0);
    chk1("rst_dmi_rst_n", dmi_rst_no, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1; host_req_i = 1'b0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    #1;
    chk1("dmi_rst_n_hold", dmi_rst_no, 1'b0);
    @(negedge clk_i); #1;
    chk1("dmi_rst_n_rise", dmi_rst_no, 1'b1);

    // dmstatus read, minimum latency
    run_txn(1'b0, 9'h044, 32'h0, 0, 0, 2'd0, 32'h0040_0382);
    // dmcontrol write with ready held low for 5 cycles
    run_txn(1'b1, 9'h040, 32'h8000_0001, 5, 0, 2'd0, 32'h1111_2222);
    // error response on a read
    run_txn(1'b0, 9'h04C, 32'h0, 0, 1, 2'd2, 32'hCAFE_F00D);
    // response never arrives in time; late response falls into IDLE
    run_txn(1'b0, 9'h044, 32'h0, 0, 30, 2'd0, 32'h5555_AAAA);
    // request never accepted
    run_txn(1'b1, 9'h010, 32'h0BAD_0BAD, 20, 0, 2'd0, 32'h0);
    // response handshake exactly in the expiry cycle
    run_txn(1'b0, 9'h044, 32'h0, 0, TO - 2, 2'd0, 32'h1357_9BDF);

    for (int i = 0; i < 20; i++) begin
      we_v   = 1'($urandom);
      addr_v = 9'($urandom);
      wd_v   = $urandom;
      rd_v   = $urandom;
      rc_v   = codes[$urandom_range(0, 3)];
      run_txn(we_v, addr_v, wd_v, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              rc_v, rd_v);
    end

    // Back-to-back with host_req_i held high; DONE must not grant
    @(negedge clk_i);
    host_we_i = 1'b0; host_addr_i = 9'h044; dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1;
    dmi_resp_i = '{data: 32'h1234_5678, resp: 2'd0};
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk_i);
      host_req_i = (c <= 4);
      if (c == 4) host_addr_i = 9'h048;
      #1;
      chk1("b2b_gnt", host_gnt_o, (c == 0) || (c == 4));
      chk1("b2b_rvalid", host_rvalid_o, (c == 3) || (c == 7));
      if (c == 3) chkw("b2b_rdata", 64'(host_rdata_o), 64'h1234_5678);
      if (c == 5) chkw("b2b_addr2", 64'(dmi_req_o.addr), 64'h12);
      if (c == 8) chk1("b2b_idle_resp_ready", dmi_resp_ready_o, 1'b0);
    end
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;

    // Reset asserted while waiting for the response
    @(negedge clk_i);
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 9'h044; dmi_req_ready_i = 1'b1;
    #1;
    chk1("mid_gnt", host_gnt_o, 1'b1);
    @(negedge clk_i); host_req_i = 1'b0;
    @(negedge clk_i); #1;
    chk1("mid_wait", dmi_resp_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk1("mid_rst_resp_ready", dmi_resp_ready_o, 1'b0);
    chk1("mid_rst_req_valid", dmi_req_valid_o, 1'b0);
    chkw("mid_rst_req_o", 64'(dmi_req_o), 64'd0);
    chk1("mid_rst_dmi_rst_n", dmi_rst_no, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      chk1("mid_rst_rvalid", host_rvalid_o, 1'b0);
    end
    rst_ni = 1'b1; dmi_req_ready_i = 1'b0;
    @(negedge clk_i); #1;
    chk1("mid_rst_rise", dmi_rst_no, 1'b1);
    chk1("mid_rst_no_rvalid", host_rvalid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
